// File: rtl/blackjack_dealer_ctrl.sv
// Blackjack round sequencer: deals from the deck block, tracks both hands
// with ace handling, runs the player hit/stand turn and the dealer
// draw-to-17 turn, and reports the round outcome.
module blackjack_dealer_ctrl #(
    parameter int DECK_LAT          = 2,
    parameter bit DEALER_HIT_SOFT17 = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hit,
    input  logic       stand,
    output logic       deck_req,
    output logic [1:0] deck_num,
    input  logic [3:0] deck_card1,
    input  logic [3:0] deck_card2,
    output logic [4:0] player_sum,
    output logic [4:0] dealer_sum,
    output logic       player_turn,
    output logic       busy,
    output logic       done,
    output logic [1:0] result,
    output logic       natural
);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_DEAL_P      = 4'd1,
        S_DEAL_D      = 4'd2,
        S_CHECK_NAT   = 4'd3,
        S_PLAYER      = 4'd4,
        S_HIT_WAIT    = 4'd5,
        S_DEALER      = 4'd6,
        S_DEALER_WAIT = 4'd7,
        S_COMPARE     = 4'd8,
        S_RESULT      = 4'd9
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(DECK_LAT);

    // Rank to points: ace is a hard 1, court cards count 10.
    function automatic logic [5:0] card_val(input logic [3:0] rank);
        logic [5:0] v;
        case (rank)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: v = {2'b00, rank};
            default: v = 6'd10;
        endcase
        return v;
    endfunction

    // Best total: promote one ace to 11 when that does not bust the hand.
    function automatic logic [4:0] best_of(input logic [5:0] hard, input logic ace);
        logic [5:0] b;
        if (ace && (hard <= 6'd11)) begin
            b = hard + 6'd10;
        end else begin
            b = hard;
        end
        return b[4:0];
    endfunction

    // States that own an outstanding deck transaction.
    function automatic logic is_wait(input state_t s);
        logic w;
        case (s)
            S_DEAL_P, S_DEAL_D, S_HIT_WAIT, S_DEALER_WAIT: w = 1'b1;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    state_t      state_r, state_nx_s;
    logic [2:0]  lat_cnt_r;
    logic        deck_req_r;
    logic [1:0]  deck_num_r;
    logic [5:0]  p_hard_r, p_hard_nx_s, d_hard_r, d_hard_nx_s;
    logic        p_ace_r, p_ace_nx_s, d_ace_r, d_ace_nx_s;
    logic [4:0]  player_sum_r, dealer_sum_r;
    logic        player_turn_r, busy_r, done_r, natural_r, natural_nx_s;
    logic [1:0]  result_r, result_nx_s;
    logic        start_ok_s, sample_s, issue_s, d_soft_s;
    logic [4:0]  p_best_s, d_best_s, p_best_nx_s, d_best_nx_s;
    logic        ace1_s, ace2_s;
    logic [5:0]  val1_s, val2_s;

    assign start_ok_s  = start && ((state_r == S_IDLE) || (state_r == S_RESULT));
    assign sample_s    = is_wait(state_r) && (lat_cnt_r == 3'd0);
    assign issue_s     = is_wait(state_nx_s) && (state_nx_s != state_r);
    assign val1_s      = card_val(deck_card1);
    assign val2_s      = card_val(deck_card2);
    assign ace1_s      = (deck_card1 == 4'd1);
    assign ace2_s      = (deck_card2 == 4'd1);
    assign p_best_s    = best_of(p_hard_r, p_ace_r);
    assign d_best_s    = best_of(d_hard_r, d_ace_r);
    assign p_best_nx_s = best_of(p_hard_nx_s, p_ace_nx_s);
    assign d_best_nx_s = best_of(d_hard_nx_s, d_ace_nx_s);
    assign d_soft_s    = d_ace_r && (d_hard_r <= 6'd11);

    // Hand accumulation: clear on an accepted start, add cards on the sample cycle.
    always_comb begin
        p_hard_nx_s = p_hard_r;
        p_ace_nx_s  = p_ace_r;
        d_hard_nx_s = d_hard_r;
        d_ace_nx_s  = d_ace_r;
        if (start_ok_s) begin
            p_hard_nx_s = 6'd0;
            p_ace_nx_s  = 1'b0;
            d_hard_nx_s = 6'd0;
            d_ace_nx_s  = 1'b0;
        end else if (sample_s) begin
            case (state_r)
                S_DEAL_P: begin
                    p_hard_nx_s = p_hard_r + val1_s + val2_s;
                    p_ace_nx_s  = p_ace_r | ace1_s | ace2_s;
                end
                S_DEAL_D: begin
                    d_hard_nx_s = d_hard_r + val1_s + val2_s;
                    d_ace_nx_s  = d_ace_r | ace1_s | ace2_s;
                end
                S_HIT_WAIT: begin
                    p_hard_nx_s = p_hard_r + val1_s;
                    p_ace_nx_s  = p_ace_r | ace1_s;
                end
                S_DEALER_WAIT: begin
                    d_hard_nx_s = d_hard_r + val1_s;
                    d_ace_nx_s  = d_ace_r | ace1_s;
                end
                default: begin
                    p_hard_nx_s = p_hard_r;
                    d_hard_nx_s = d_hard_r;
                end
            endcase
        end else begin
            p_hard_nx_s = p_hard_r;
            d_hard_nx_s = d_hard_r;
        end
    end

    // Round sequencing and outcome decisions.
    always_comb begin
        state_nx_s   = state_r;
        result_nx_s  = result_r;
        natural_nx_s = natural_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_nx_s = S_DEAL_P;
                else       state_nx_s = state_r;
            end
            S_DEAL_P: begin
                if (sample_s) state_nx_s = S_DEAL_D;
                else          state_nx_s = state_r;
            end
            S_DEAL_D: begin
                if (sample_s) state_nx_s = S_CHECK_NAT;
                else          state_nx_s = state_r;
            end
            S_CHECK_NAT: begin
                if ((p_best_s == 5'd21) && (d_best_s == 5'd21)) begin
                    state_nx_s  = S_RESULT;
                    result_nx_s = 2'b11;
                end else if (p_best_s == 5'd21) begin
                    state_nx_s   = S_RESULT;
                    result_nx_s  = 2'b01;
                    natural_nx_s = 1'b1;
                end else if (d_best_s == 5'd21) begin
                    state_nx_s  = S_RESULT;
                    result_nx_s = 2'b10;
                end else begin
                    state_nx_s = S_PLAYER;
                end
            end
            S_PLAYER: begin
                // stand has priority over a simultaneous hit
                if (stand)    state_nx_s = S_DEALER;
                else if (hit) state_nx_s = S_HIT_WAIT;
                else          state_nx_s = state_r;
            end
            S_HIT_WAIT: begin
                if (!sample_s) begin
                    state_nx_s = state_r;
                end else if (p_best_nx_s > 5'd21) begin
                    state_nx_s  = S_RESULT;
                    result_nx_s = 2'b10;
                end else if (p_best_nx_s == 5'd21) begin
                    state_nx_s = S_DEALER;
                end else begin
                    state_nx_s = S_PLAYER;
                end
            end
            S_DEALER: begin
                if ((d_best_s < 5'd17) ||
                    ((d_best_s == 5'd17) && d_soft_s && DEALER_HIT_SOFT17)) begin
                    state_nx_s = S_DEALER_WAIT;
                end else begin
                    state_nx_s = S_COMPARE;
                end
            end
            S_DEALER_WAIT: begin
                if (sample_s) state_nx_s = S_DEALER;
                else          state_nx_s = state_r;
            end
            S_COMPARE: begin
                state_nx_s = S_RESULT;
                if (d_best_s > 5'd21)           result_nx_s = 2'b01;
                else if (p_best_s > d_best_s)   result_nx_s = 2'b01;
                else if (p_best_s < d_best_s)   result_nx_s = 2'b10;
                else                            result_nx_s = 2'b11;
            end
            S_RESULT: begin
                if (start) begin
                    state_nx_s   = S_DEAL_P;
                    result_nx_s  = 2'b00;
                    natural_nx_s = 1'b0;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s   = S_IDLE;
                result_nx_s  = 2'b00;
                natural_nx_s = 1'b0;
            end
        endcase
    end

    // State, hands, deck handshake and all outputs registered together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= S_IDLE;
            lat_cnt_r     <= 3'd0;
            deck_req_r    <= 1'b0;
            deck_num_r    <= 2'd0;
            p_hard_r      <= 6'd0;
            p_ace_r       <= 1'b0;
            d_hard_r      <= 6'd0;
            d_ace_r       <= 1'b0;
            player_sum_r  <= 5'd0;
            dealer_sum_r  <= 5'd0;
            player_turn_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            result_r      <= 2'b00;
            natural_r     <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            p_hard_r      <= p_hard_nx_s;
            p_ace_r       <= p_ace_nx_s;
            d_hard_r      <= d_hard_nx_s;
            d_ace_r       <= d_ace_nx_s;
            player_sum_r  <= p_best_nx_s;
            dealer_sum_r  <= d_best_nx_s;
            result_r      <= result_nx_s;
            natural_r     <= natural_nx_s;
            player_turn_r <= (state_nx_s == S_PLAYER);
            busy_r        <= (state_nx_s != S_IDLE) && (state_nx_s != S_RESULT);
            done_r        <= (state_nx_s == S_RESULT);
            deck_req_r    <= issue_s;
            if (issue_s) begin
                deck_num_r <= ((state_nx_s == S_DEAL_P) || (state_nx_s == S_DEAL_D)) ? 2'd2 : 2'd1;
                lat_cnt_r  <= LAT_INIT;
            end else begin
                deck_num_r <= 2'd0;
                lat_cnt_r  <= (lat_cnt_r != 3'd0) ? (lat_cnt_r - 3'd1) : 3'd0;
            end
        end
    end

    assign deck_req    = deck_req_r;
    assign deck_num    = deck_num_r;
    assign player_sum  = player_sum_r;
    assign dealer_sum  = dealer_sum_r;
    assign player_turn = player_turn_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign result      = result_r;
    assign natural     = natural_r;

endmodule

// File: tb/tb_blackjack_dealer_ctrl.sv
// Bench for blackjack_dealer_ctrl: scripted deck model, table of whole-round
// scenarios, plus hand-written reset and input-gating sequences. Two
// instances run side by side, differing only in the soft-17 dealer rule.
module tb_blackjack_dealer_ctrl;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic       stand = 1'b0;
    logic [3:0] deck_card1, deck_card2;

    logic       deck_req0, deck_req1;
    logic [1:0] deck_num0, deck_num1;
    logic [4:0] psum0, dsum0, psum1, dsum1;
    logic       pturn0, busy0, done0, nat0, pturn1, busy1, done1, nat1;
    logic [1:0] result0, result1;

    blackjack_dealer_ctrl #(.DECK_LAT(LAT), .DEALER_HIT_SOFT17(1'b0)) dut (
        .clk(clk), .reset(reset), .start(start), .hit(hit), .stand(stand),
        .deck_req(deck_req0), .deck_num(deck_num0),
        .deck_card1(deck_card1), .deck_card2(deck_card2),
        .player_sum(psum0), .dealer_sum(dsum0), .player_turn(pturn0),
        .busy(busy0), .done(done0), .result(result0), .natural(nat0));

    blackjack_dealer_ctrl #(.DECK_LAT(LAT), .DEALER_HIT_SOFT17(1'b1)) dut_s17 (
        .clk(clk), .reset(reset), .start(start), .hit(hit), .stand(stand),
        .deck_req(deck_req1), .deck_num(deck_num1),
        .deck_card1(deck_card1), .deck_card2(deck_card2),
        .player_sum(psum1), .dealer_sum(dsum1), .player_turn(pturn1),
        .busy(busy1), .done(done1), .result(result1), .natural(nat1));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // deck script written by the stimulus, consumed by the deck model
    int script [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int round_base = 0;

    // deck model state
    int         cd = 0;
    int         req_any = 0;
    int         req0_total = 0;
    int         proto_bad = 0;
    logic [1:0] cur_num = 2'd0;
    logic       prev_req0 = 1'b0;
    logic       prev_req1 = 1'b0;

    // Deck model: answers a request exactly LAT cycles later, zero otherwise.
    always @(posedge clk) begin
        #1;
        deck_card1 = 4'd0;
        deck_card2 = 4'd0;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                if (rd_ptr < wr_ptr) begin
                    deck_card1 = 4'(script[rd_ptr]);
                    rd_ptr = rd_ptr + 1;
                end
                if (cur_num == 2'd2 && rd_ptr < wr_ptr) begin
                    deck_card2 = 4'(script[rd_ptr]);
                    rd_ptr = rd_ptr + 1;
                end
            end
        end
        if (deck_req0 || deck_req1) begin
            cur_num = deck_req0 ? deck_num0 : deck_num1;
            if (cur_num != (((req_any - round_base) < 2) ? 2'd2 : 2'd1)) proto_bad = proto_bad + 1;
            req_any = req_any + 1;
            cd = LAT;
        end
        if (deck_req0) req0_total = req0_total + 1;
        if ((deck_req0 && prev_req0) || (deck_req1 && prev_req1)) proto_bad = proto_bad + 1;
        if ((!deck_req0 && deck_num0 != 2'd0) || (!deck_req1 && deck_num1 != 2'd0)) proto_bad = proto_bad + 1;
        prev_req0 = deck_req0;
        prev_req1 = deck_req1;
    end

    typedef struct {
        string name;
        int p1, p2, d1, d2;
        int nhit, h0, h1;
        int ndraw, r0, r1;
        int psum, dsum, res, nat, nreq, res_s, dsum_s;
    } row_t;

    row_t rows [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int c);
        script[wr_ptr] = c;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_turn_or_done(input string name);
        int n = 0;
        while (!(pturn0 || done0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, ".wait_turn"}, 32'(n < 60), 32'd1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(done0 && done1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, ".wait_done"}, 32'(n < 200), 32'd1);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_round(input row_t r);
        int base0;
        int hc [2];
        hc[0] = r.h0;
        hc[1] = r.h1;
        base0 = req0_total;
        round_base = req_any;
        push(r.p1); push(r.p2); push(r.d1); push(r.d2);
        if (r.nhit > 0) push(r.h0);
        if (r.nhit > 1) push(r.h1);
        if (r.ndraw > 0) push(r.r0);
        if (r.ndraw > 1) push(r.r1);
        pulse_start();
        wait_turn_or_done(r.name);
        for (int i = 0; i < r.nhit; i++) begin
            if (pturn0) begin
                hit = 1'b1;
                @(negedge clk);
                hit = 1'b0;
                wait_turn_or_done(r.name);
            end
        end
        if (pturn0) begin
            stand = 1'b1;
            @(negedge clk);
            stand = 1'b0;
        end
        wait_done(r.name);
        repeat (4) @(negedge clk);
        check({r.name, ".psum"},   32'(psum0),   32'(r.psum));
        check({r.name, ".dsum"},   32'(dsum0),   32'(r.dsum));
        check({r.name, ".result"}, 32'(result0), 32'(r.res));
        check({r.name, ".natural"},32'(nat0),    32'(r.nat));
        check({r.name, ".nreq"},   32'(req0_total - base0), 32'(r.nreq));
        check({r.name, ".busy"},   32'(busy0),   32'd0);
        check({r.name, ".s17_psum"},   32'(psum1),   32'(r.psum));
        check({r.name, ".s17_dsum"},   32'(dsum1),   32'(r.dsum_s));
        check({r.name, ".s17_result"}, 32'(result1), 32'(r.res_s));
        check({r.name, ".cards_left"}, 32'(wr_ptr - rd_ptr), 32'd0);
        check({r.name, ".deck_proto"}, 32'(proto_bad), 32'd0);
    endtask

    initial begin
        //            name      p1 p2 d1 d2 nh h0 h1 nd r0 r1 ps ds rs nt nq rs17 ds17
        rows[0]  = '{"push17",  10, 7, 9, 8, 0, 0, 0, 0, 0, 0, 17, 17, 3, 0, 2, 3, 17};
        rows[1]  = '{"natural",  1,13,10, 6, 0, 0, 0, 0, 0, 0, 21, 16, 1, 1, 2, 1, 16};
        rows[2]  = '{"bust",    10, 6,10, 6, 1, 9, 0, 0, 0, 0, 25, 16, 2, 0, 3, 2, 16};
        rows[3]  = '{"soft16",   1, 5,10, 2, 1,10, 0, 1, 5, 0, 16, 17, 2, 0, 4, 2, 17};
        rows[4]  = '{"soft17",  10, 9, 1, 6, 0, 0, 0, 1, 4, 0, 19, 17, 1, 0, 2, 2, 21};
        rows[5]  = '{"auto21",  10, 5,10, 7, 1, 6, 0, 0, 0, 0, 21, 17, 1, 0, 3, 1, 17};
        rows[6]  = '{"dbust",   10, 2,10, 6, 0, 0, 0, 1,10, 0, 12, 26, 1, 0, 3, 1, 26};
        rows[7]  = '{"dnat",    10, 9, 1,10, 0, 0, 0, 0, 0, 0, 19, 21, 2, 0, 2, 2, 21};
        rows[8]  = '{"bothnat",  1,10,13, 1, 0, 0, 0, 0, 0, 0, 21, 21, 3, 0, 2, 3, 21};
        rows[9]  = '{"lower",   10, 8,10, 9, 0, 0, 0, 0, 0, 0, 18, 19, 2, 0, 2, 2, 19};
        rows[10] = '{"twohits",  2, 3,10, 8, 2, 4, 1, 0, 0, 0, 20, 18, 1, 0, 4, 1, 18};

        // reset state
        repeat (3) @(negedge clk);
        check("reset.outs0", 32'({deck_req0, deck_num0, psum0, dsum0, pturn0, busy0, done0, result0, nat0}), 32'd0);
        check("reset.outs1", 32'({deck_req1, deck_num1, psum1, dsum1, pturn1, busy1, done1, result1, nat1}), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_round(rows[i]);
        end

        // hit and stand together: stand wins, no card request
        begin
            int base0;
            base0 = req0_total;
            round_base = req_any;
            push(10); push(8); push(10); push(9);
            pulse_start();
            wait_turn_or_done("both");
            hit = 1'b1;
            stand = 1'b1;
            @(negedge clk);
            hit = 1'b0;
            stand = 1'b0;
            check("both.turn_drop", 32'(pturn0), 32'd0);
            check("both.no_req", 32'(deck_req0), 32'd0);
            wait_done("both");
            repeat (2) @(negedge clk);
            check("both.nreq", 32'(req0_total - base0), 32'd2);
            check("both.result", 32'(result0), 32'd2);
            check("both.psum", 32'(psum0), 32'd18);
            check("both.dsum", 32'(dsum0), 32'd19);
        end

        // start/hit outside their windows are ignored
        begin
            int base0;
            base0 = req0_total;
            round_base = req_any;
            push(10); push(7); push(9); push(8);
            pulse_start();
            start = 1'b1;
            hit = 1'b1;
            @(negedge clk);
            start = 1'b0;
            hit = 1'b0;
            wait_turn_or_done("gate");
            pulse_start();
            check("gate.turn_kept", 32'(pturn0), 32'd1);
            check("gate.busy_kept", 32'(busy0), 32'd1);
            stand = 1'b1;
            @(negedge clk);
            stand = 1'b0;
            wait_done("gate");
            repeat (4) @(negedge clk);
            check("gate.nreq", 32'(req0_total - base0), 32'd2);
            check("gate.result", 32'(result0), 32'd3);
            hit = 1'b1;
            @(negedge clk);
            hit = 1'b0;
            repeat (3) @(negedge clk);
            check("gate.result_hit_ignored", 32'(req0_total - base0), 32'd2);
            check("gate.done_held", 32'(done0), 32'd1);
            check("gate.sum_held", 32'(psum0), 32'd17);
        end

        // reset during HIT_WAIT with a simultaneous start; late card ignored
        begin
            round_base = req_any;
            push(10); push(2); push(10); push(7); push(5);
            pulse_start();
            wait_turn_or_done("rst");
            hit = 1'b1;
            @(negedge clk);
            hit = 1'b0;
            check("rst.hit_req", 32'(deck_req0), 32'd1);
            reset = 1'b0;
            start = 1'b1;
            @(negedge clk);
            reset = 1'b1;
            start = 1'b0;
            check("rst.outs0", 32'({deck_req0, deck_num0, psum0, dsum0, pturn0, busy0, done0, result0, nat0}), 32'd0);
            check("rst.outs1", 32'({deck_req1, deck_num1, psum1, dsum1, pturn1, busy1, done1, result1, nat1}), 32'd0);
            repeat (4) @(negedge clk);
            check("rst.late_outs0", 32'({deck_req0, deck_num0, psum0, dsum0, pturn0, busy0, done0, result0, nat0}), 32'd0);
            check("rst.late_consumed", 32'(wr_ptr - rd_ptr), 32'd0);
        end

        // recovery round after the abort
        run_round(rows[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
